// File: rtl/video_text_ram.sv
// Text-console character RAM with a command front end: write-at-cursor, set-cursor,
// hardware clear and one-line scroll implemented as a rotating top-of-screen base pointer.
module video_text_ram #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    COLS       = 80,
  parameter int                    ROWS       = 60,
  parameter string                 INIT_FILE  = "",
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(32'h20),
  parameter int                    ADDR_WIDTH = $clog2(COLS*ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [ADDR_WIDTH-1:0] cursor,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int                    SIZE       = COLS*ROWS;
  localparam logic [ADDR_WIDTH:0]   SIZE_X     = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH:0]   COLS_X     = (ADDR_WIDTH+1)'(COLS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(SIZE-1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL   = ADDR_WIDTH'(COLS-1);
  localparam logic [ADDR_WIDTH-1:0] BOTTOM_ROW = ADDR_WIDTH'(SIZE-COLS);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SCROLL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] fill_cnt, fill_n;
  logic [ADDR_WIDTH-1:0] top_base, top_n;
  logic [ADDR_WIDTH-1:0] cursor_n;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]   top_plus_line;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Logical-to-physical mapping; base is always a row start below SIZE, so one subtract suffices.
  function automatic logic [ADDR_WIDTH-1:0] phys(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [ADDR_WIDTH-1:0] base);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, base};
    if (sum >= SIZE_X) sum = sum - SIZE_X;
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE and out of reset, so a command held during a fill waits, never drops.
  assign cmd_ready     = (state == S_IDLE) && !reset;
  assign busy          = (state != S_IDLE);
  assign top_plus_line = {1'b0, top_base} + COLS_X;

  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    top_n     = top_base;
    cursor_n  = cursor;
    mem_we    = 1'b0;
    mem_waddr = phys(cursor, top_base);
    mem_wdata = cmd_data;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_WRITE: begin
              mem_we = 1'b1;
              if (cursor == LAST_CELL) begin
                cursor_n = BOTTOM_ROW;
                fill_n   = '0;
                state_n  = S_SCROLL;
              end else begin
                cursor_n = cursor + ADDR_WIDTH'(1);
              end
            end
            OP_SET: begin
              if ({1'b0, cmd_addr} < SIZE_X) cursor_n = cmd_addr;
            end
            OP_CLEAR: begin
              fill_n   = '0;
              top_n    = '0;
              cursor_n = '0;
              state_n  = S_CLEAR;
            end
            default: begin
              fill_n  = '0;
              state_n = S_SCROLL;
              if (cursor >= COLS_A) cursor_n = cursor - COLS_A;
            end
          endcase
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = fill_cnt;
        mem_wdata = FILL_VALUE;
        if (fill_cnt == LAST_CELL) begin
          fill_n  = '0;
          state_n = S_IDLE;
        end else begin
          fill_n = fill_cnt + ADDR_WIDTH'(1);
        end
      end
      S_SCROLL: begin
        // The old top line is blanked in place and becomes the new bottom line.
        mem_we    = 1'b1;
        mem_waddr = top_base + fill_cnt;
        mem_wdata = FILL_VALUE;
        if (fill_cnt == LAST_COL) begin
          fill_n  = '0;
          top_n   = (top_plus_line >= SIZE_X) ? '0 : top_plus_line[ADDR_WIDTH-1:0];
          state_n = S_IDLE;
        end else begin
          fill_n = fill_cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      top_base <= '0;
      cursor   <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_n;
      top_base <= top_n;
      cursor   <= cursor_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} >= SIZE_X) begin
      rd_data <= FILL_VALUE;
    end else begin
      rd_data <= mem[phys(rd_addr, top_base)];
    end
  end

endmodule

// File: tb/tb_video_text_ram.sv
// Bench for video_text_ram: directed scenarios then random commands, checked against a
// logical-screen model (scroll = shift lines up) through an expected-read queue.
module tb_video_text_ram;

    localparam int         COLS = 4;
    localparam int         ROWS = 3;
    localparam int         SIZE = COLS*ROWS;
    localparam logic [7:0] FILL = 8'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_addr;
    logic [3:0] cursor;
    logic       busy;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    logic [7:0] scr [SIZE];
    logic [7:0] snap [SIZE];
    logic [3:0] m_cur;
    logic [7:0] exp_q [$];
    logic [3:0] addr_q [$];
    logic       rd_req;
    int         n_checks = 0;
    int         n_errors = 0;

    video_text_ram #(
        .DATA_WIDTH(8), .COLS(COLS), .ROWS(ROWS), .INIT_FILE(""), .FILL_VALUE(FILL)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_addr(cmd_addr), .cursor(cursor),
        .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur", name);
    endtask

    function automatic logic [7:0] exp_rd(input int a);
        return (a >= SIZE) ? FILL : scr[a];
    endfunction

    task automatic scroll_model();
        for (int i = 0; i < SIZE; i++) begin
            if (i < SIZE - COLS) scr[i] = scr[i + COLS];
            else scr[i] = FILL;
        end
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] d, input logic [3:0] a);
        case (op)
            2'b00: begin
                scr[m_cur] = d;
                if (int'(m_cur) == SIZE - 1) begin
                    scroll_model();
                    m_cur = 4'(SIZE - COLS);
                end else begin
                    m_cur = m_cur + 4'd1;
                end
            end
            2'b01: if (int'(a) < SIZE) m_cur = a;
            2'b10: begin
                for (int i = 0; i < SIZE; i++) scr[i] = FILL;
                m_cur = '0;
            end
            default: begin
                scroll_model();
                if (int'(m_cur) >= COLS) m_cur = m_cur - 4'(COLS);
            end
        endcase
    endtask

    // Presents a command and holds it until accepted; stalls counts cycles spent waiting.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic [3:0] a,
                          output int stalls);
        @(negedge clk);
        cmd_op = op; cmd_data = d; cmd_addr = a; cmd_valid = 1'b1;
        stalls = 0;
        while (!cmd_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!cmd_ready) begin
            fail("cmd_accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_apply(op, d, a);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        @(negedge clk);
        while (busy && n < 200) begin
            if (cmd_ready) ready_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        if (busy) fail("busy_timeout");
    endtask

    task automatic rd(input int a);
        @(negedge clk);
        rd_addr = 4'(a);
        rd_req  = 1'b1;
        exp_q.push_back(exp_rd(a));
        addr_q.push_back(4'(a));
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < SIZE; i++) rd(i);
    endtask

    task automatic monitor();
        logic       req_q;
        logic [7:0] e;
        logic [3:0] ea;
        forever begin
            @(posedge clk);
            req_q = rd_req;
            @(negedge clk);
            if (req_q) begin
                if (exp_q.size() == 0) begin
                    fail("rd_queue_underflow");
                end else begin
                    e  = exp_q.pop_front();
                    ea = addr_q.pop_front();
                    check($sformatf("rd_data@%0d", ea), 32'(rd_data), 32'(e));
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         st, n, r, eb;
        logic       rb;
        logic [1:0] op;
        logic [7:0] d;
        logic [3:0] a;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_addr = '0;
        rd_addr = '0; rd_req = 1'b0; m_cur = '0;
        for (int i = 0; i < SIZE; i++) scr[i] = FILL;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_cursor", 32'(cursor), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(cmd_ready), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        @(negedge clk) reset = 1'b0;

        // Clear screen
        do_cmd(2'b10, 8'h00, 4'd0, st);
        wait_idle(n, rb);
        check("clear_busy_cycles", 32'(n), 12);
        check("clear_ready_low", 32'(rb), 0);
        check("clear_cursor", 32'(cursor), 0);
        rd_all();

        // Plain writes and out-of-range read
        do_cmd(2'b00, 8'h41, 4'd0, st);
        do_cmd(2'b00, 8'h42, 4'd0, st);
        do_cmd(2'b00, 8'h43, 4'd0, st);
        check("write_cursor", 32'(cursor), 3);
        rd(0); rd(1); rd(2); rd(12);

        // Auto-scroll on write at the last cell
        do_cmd(2'b01, 8'h00, 4'd11, st);
        do_cmd(2'b00, 8'h5A, 4'd0, st);
        check("autoscroll_cursor", 32'(cursor), 8);
        wait_idle(n, rb);
        check("autoscroll_busy_cycles", 32'(n), 4);
        rd(7);
        rd_all();

        // Three explicit scrolls, each with a write held while busy
        do_cmd(2'b10, 8'h00, 4'd0, st);
        wait_idle(n, rb);
        do_cmd(2'b00, 8'h31, 4'd0, st);
        for (int k = 0; k < 3; k++) begin
            do_cmd(2'b11, 8'h00, 4'd0, st);
            do_cmd(2'b00, 8'h61 + 8'(k), 4'd0, st);
            check($sformatf("scroll%0d_stall_cycles", k), 32'(st), 4);
            check($sformatf("scroll%0d_cursor", k), 32'(cursor), 32'(m_cur));
            rd_all();
        end

        // Reset during the fifth clear cycle aborts the fill
        do_cmd(2'b01, 8'h00, 4'd0, st);
        for (int i = 0; i < SIZE - 1; i++) do_cmd(2'b00, 8'(i * 17 + 3), 4'd0, st);
        wait_idle(n, rb);
        snap = scr;
        do_cmd(2'b10, 8'h00, 4'd0, st);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_cursor", 32'(cursor), 0);
        check("abort_rd_data", 32'(rd_data), 0);
        check("abort_ready", 32'(cmd_ready), 0);
        scr = snap;
        for (int i = 0; i < COLS; i++) scr[i] = FILL;
        m_cur = '0;
        @(negedge clk) reset = 1'b0;
        rd_all();

        // Out-of-range set-cursor, then read-before-write on one edge
        do_cmd(2'b01, 8'h00, 4'd6, st);
        do_cmd(2'b01, 8'h00, 4'd12, st);
        check("set_oor_cursor", 32'(cursor), 6);
        do_cmd(2'b01, 8'h00, 4'd5, st);
        @(negedge clk);
        check("rbw_ready", 32'(cmd_ready), 1);
        cmd_op = 2'b00; cmd_data = ~scr[5]; cmd_valid = 1'b1;
        rd_addr = 4'd5; rd_req = 1'b1;
        exp_q.push_back(exp_rd(5));
        addr_q.push_back(4'd5);
        @(posedge clk);
        model_apply(2'b00, cmd_data, 4'd0);
        #1 cmd_valid = 1'b0;
        exp_q.push_back(exp_rd(5));
        addr_q.push_back(4'd5);
        @(posedge clk);
        #1 rd_req = 1'b0;

        // Random command mix
        for (int it = 0; it < 80; it++) begin
            r  = $urandom_range(0, 99);
            op = (r < 50) ? 2'b00 : (r < 72) ? 2'b01 : (r < 93) ? 2'b11 : 2'b10;
            d  = 8'($urandom_range(0, 255));
            a  = 4'($urandom_range(0, SIZE + 1));
            eb = (op == 2'b10) ? SIZE : (op == 2'b11) ? COLS :
                 (op == 2'b00 && int'(m_cur) == SIZE - 1) ? COLS : 0;
            do_cmd(op, d, a, st);
            wait_idle(n, rb);
            check("rand_busy_cycles", 32'(n), 32'(eb));
            check("rand_cursor", 32'(cursor), 32'(m_cur));
            rd($urandom_range(0, SIZE + 1));
            rd($urandom_range(0, SIZE + 1));
        end
        rd_all();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
